// File: rtl/tone_sequencer.sv
// -----------------------------------------------------------------------------
// tone_sequencer
//   Direct digital synthesis tone generator. A prescaler produces one sample
//   tick every PRESCALE+1 clocks; each tick advances a phase accumulator by the
//   tune register. The top 5 phase bits address an external combinational
//   32-entry sine table. The returned value is captured as the current sample
//   and also rendered as a 1-bit PWM stream.
//
//   Optional feature: define TONE_VOLUME_EN to add a 2-bit volume input. The
//   captured table value is then attenuated around mid-scale (8) by an
//   arithmetic right shift.
//
// Parameters
//   ACC_WIDTH  phase accumulator width (8..24)
//   PRESCALE   tick period is PRESCALE+1 clocks (2..65535)
//
// Ports
//   clk           single clock, rising edge
//   rst_n         asynchronous active-low reset
//   enable        level, 1 = generate tone
//   sync_clr      pulse, clears phase accumulator and prescaler
//   tune_word     phase increment per tick
//   tune_load     strobe capturing tune_word
//   rom_addr      registered sine table address (top 5 phase bits)
//   rom_data      sine table value for rom_addr, same cycle
//   volume        (TONE_VOLUME_EN only) attenuation shift 0..3
//   sample        registered current sample, offset binary (8 = zero)
//   sample_valid  one-cycle pulse when sample updates
//   pwm_out       registered PWM rendering of sample
//   dbg_state     current FSM state (IDLE=0, RUN=1, FETCH=2)
//
// Handshake: there is no backpressure. sample_valid is a single-cycle
// qualifier; sample holds its value until the next pulse.
// -----------------------------------------------------------------------------
module tone_sequencer #(
   parameter int ACC_WIDTH = 16,
   parameter int PRESCALE  = 15
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic                 sync_clr,
   input  logic [ACC_WIDTH-1:0] tune_word,
   input  logic                 tune_load,
   output logic [4:0]           rom_addr,
   input  logic [3:0]           rom_data,
`ifdef TONE_VOLUME_EN
   input  logic [1:0]           volume,
`endif
   output logic [3:0]           sample,
   output logic                 sample_valid,
   output logic                 pwm_out,
   output logic [1:0]           dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FETCH = 2'd2
   } state_t;

   localparam logic [15:0] PRE_MAX = 16'(PRESCALE);

   state_t               state_q, state_d;
   logic [15:0]          pre_cnt_q, pre_cnt_d;
   logic [ACC_WIDTH-1:0] phase_q, phase_d;
   logic [ACC_WIDTH-1:0] tune_q;
   logic [3:0]           sample_q;
   logic                 sample_valid_q;
   logic [3:0]           pwm_cnt_q;
   logic                 pwm_out_q;
   logic                 tick;
   logic [3:0]           capture_val;

   // Table value as it will be stored into sample.
`ifdef TONE_VOLUME_EN
   logic signed [4:0] vol_diff;
   logic signed [4:0] vol_shift;
   logic [4:0]        vol_res;

   always_comb begin
      vol_diff    = signed'({1'b0, rom_data}) - 5'sd8;
      vol_shift   = vol_diff >>> volume;
      vol_res     = unsigned'(vol_shift) + 5'd8;
      capture_val = vol_res[3:0];
   end
`else
   always_comb begin
      capture_val = rom_data;
   end
`endif

   always_comb begin
      state_d   = state_q;
      pre_cnt_d = pre_cnt_q;
      phase_d   = phase_q;
      tick      = 1'b0;
      case (state_q)
         IDLE: begin
            pre_cnt_d = '0;
            if (enable) state_d = RUN;
         end
         RUN: begin
            // Dropping enable wins over a tick: no accumulation on exit.
            if (!enable) begin
               state_d   = IDLE;
               pre_cnt_d = '0;
            end else if (pre_cnt_q == PRE_MAX) begin
               tick      = 1'b1;
               pre_cnt_d = '0;
               phase_d   = phase_q + tune_q;
               state_d   = FETCH;
            end else begin
               pre_cnt_d = pre_cnt_q + 16'd1;
            end
         end
         FETCH: begin
            if (enable) begin
               state_d   = RUN;
               pre_cnt_d = pre_cnt_q + 16'd1;
            end else begin
               state_d   = IDLE;
               pre_cnt_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
      // A clear swallows a coincident tick entirely: the FSM stays in RUN.
      if (sync_clr) begin
         phase_d   = '0;
         pre_cnt_d = '0;
         if (tick) state_d = state_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         pre_cnt_q      <= '0;
         phase_q        <= '0;
         tune_q         <= '0;
         sample_q       <= 4'h8;
         sample_valid_q <= 1'b0;
         pwm_cnt_q      <= '0;
         pwm_out_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         pre_cnt_q <= pre_cnt_d;
         phase_q   <= phase_d;
         // The tick above used the old tune_q; the new word applies afterwards.
         if (tune_load) tune_q <= tune_word;
         if (state_q == FETCH) sample_q <= capture_val;
         sample_valid_q <= (state_q == FETCH);
         if (state_q != IDLE) pwm_cnt_q <= pwm_cnt_q + 4'd1;
         // Looking at the next state keeps pwm_out low for every IDLE cycle.
         pwm_out_q <= (state_d != IDLE) && (pwm_cnt_q < sample_q);
      end
   end

   assign rom_addr     = phase_q[ACC_WIDTH-1 -: 5];
   assign sample       = sample_q;
   assign sample_valid = sample_valid_q;
   assign pwm_out      = pwm_out_q;
   assign dbg_state    = state_q;

endmodule

// File: doc/tone_sequencer.md
TONE_SEQUENCER -- requirements
Module: tone_sequencer

Interface
REQ-001 The block SHALL have parameter ACC_WIDTH, default 16, phase accumulator width; legal range 8..24.
REQ-002 The block SHALL have parameter PRESCALE, default 15, giving one sample tick every PRESCALE+1 clocks; legal range 2..65535.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  level; 1 = generate tone, 0 = idle.
REQ-006 sync_clr  input  1  one-cycle pulse clearing phase and prescaler.
REQ-007 tune_word  input  ACC_WIDTH  phase increment per sample tick.
REQ-008 tune_load  input  1  one-cycle strobe capturing tune_word.
REQ-009 rom_addr  output  5  registered address driven to the external combinational 32-entry sine table.
REQ-010 rom_data  input  4  offset-binary table value for rom_addr, valid in the same cycle.
REQ-011 sample  output  4  registered current sample, offset-binary (8 = zero).
REQ-012 sample_valid  output  1  one-cycle pulse when sample updates.
REQ-013 pwm_out  output  1  registered 1-bit PWM rendering of sample.

Function
REQ-014 FSM states SHALL be IDLE, RUN, FETCH; reset state IDLE.
REQ-015 IDLE: pre_cnt held at 0, phase_acc retained, pwm_out 0; enable=1 -> RUN next cycle.
REQ-016 RUN: pre_cnt increments each clock; at pre_cnt==PRESCALE (tick), pre_cnt wraps to 0, phase_acc <= phase_acc + tune_reg mod 2^ACC_WIDTH, -> FETCH.
REQ-017 FETCH: sample <= f(rom_data), sample_valid=1 in the following cycle, pre_cnt keeps counting, -> RUN (or IDLE if enable=0).
REQ-018 rom_addr SHALL equal phase_acc[ACC_WIDTH-1:ACC_WIDTH-5] at all times.
REQ-019 Latency: tick in cycle N -> new rom_addr in N+1 -> sample and sample_valid in N+2.
REQ-020 tune_load SHALL update tune_reg at the clock edge in any state; if tune_load coincides with a tick, the tick uses the old tune_reg.
REQ-021 tune_word=0 SHALL freeze rom_addr while ticks and sample_valid continue.
REQ-022 sync_clr SHALL set phase_acc=0 and pre_cnt=0, has priority over a coincident tick, and leaves state, sample and tune_reg unchanged.
REQ-023 enable falling in RUN -> IDLE next cycle, no accumulation; falling in FETCH -> the capture completes, then IDLE.
REQ-024 Phase wrap past 2^ACC_WIDTH-1 SHALL be silent modulo arithmetic, no flag.
REQ-025 pwm_cnt (4 bits) SHALL free-run 0..15 outside IDLE; pwm_out <= (pwm_cnt < sample); sample=0 gives constant 0, sample=15 gives 15/16 duty.

Reset
REQ-026 rst_n low SHALL asynchronously force: state IDLE, phase_acc 0, rom_addr 0, pre_cnt 0, pwm_cnt 0, tune_reg 0, sample 4'h8, sample_valid 0, pwm_out 0.
REQ-027 Reset asserted mid-FETCH SHALL discard the pending capture; no sample_valid after release until the next tick.

Configuration
REQ-028 Macro TONE_VOLUME_EN SHALL control the volume feature.
REQ-029 With TONE_VOLUME_EN defined: input volume[1:0] is added; f(d) = 8 + ((d-8) arithmetic-shifted right by volume), computed signed in 5 bits.
REQ-030 Without TONE_VOLUME_EN: no volume port; f(d) = d.

Verification
REQ-031 Reset: assert rst_n=0 mid-run -> all outputs at REQ-026 values immediately, sample=8, no sample_valid for PRESCALE+2 clocks after release.
REQ-032 Sweep: ACC_WIDTH=16, PRESCALE=3, tune_word=16'h0800 -> rom_addr steps +1 every 4 clocks, samples follow the table, rom_addr wraps 31->0 after 32 ticks.
REQ-033 Load/tick collision: tune_reg=16'h0800, load 16'h1000 on a tick cycle -> that step +1, subsequent steps +2.
REQ-034 sync_clr on a tick cycle, phase_acc=16'h7800 -> phase_acc=0, rom_addr=0, next tick after PRESCALE+1 clocks.
REQ-035 PWM: hold sample=4'hC -> pwm_out high exactly 12 of every 16 clocks; sample=0 -> pwm_out never high.
REQ-036 TONE_VOLUME_EN, volume=2: rom_data=4'hF -> sample=9; rom_data=4'h0 -> sample=6; volume=0 -> sample=rom_data.
